// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic-light timer and controllers
package traffic_pkg;

  localparam int SEC_W = 6;

  localparam int T_SHORT_DEF = 3;
  localparam int T_LONG_DEF  = 25;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } timer_state_t;

  // Light encoding shared with the controllers that drive this timer.
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2,
    LIGHT_OFF    = 2'd3
  } light_t;

endpackage

// File: rtl/sec_down_timer.sv
// rtl/sec_down_timer.sv - restartable one-shot timer counting SEC whole seconds of CLK_FREQ cycles
module sec_down_timer
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SEC      = T_SHORT_DEF
) (
  input  logic             clk,
  input  logic             glob_rst,
  input  logic             start,
  output logic             timeout,
  output logic             busy,
  output logic [SEC_W-1:0] sec_left
);

  localparam int SUB_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [SUB_W-1:0] SUB_RELOAD = SUB_W'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0] SEC_RELOAD = SEC_W'(SEC - 1);

  timer_state_t     state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             timeout_q, timeout_d;
  logic [SEC_W-1:0] sec_left_q, sec_left_d;

  always_ff @(posedge clk) begin
    if (glob_rst) begin
      state_q    <= TMR_IDLE;
      sub_q      <= '0;
      sec_q      <= '0;
      timeout_q  <= 1'b0;
      sec_left_q <= '0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      sec_q      <= sec_d;
      timeout_q  <= timeout_d;
      sec_left_q <= sec_left_d;
    end
  end

  // A start always wins, so a start on the expiry edge silently restarts the run.
  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    sec_d      = sec_q;
    timeout_d  = 1'b0;
    sec_left_d = '0;

    if (start) begin
      state_d = TMR_RUN;
      sub_d   = SUB_RELOAD;
      sec_d   = SEC_RELOAD;
    end else if (state_q == TMR_RUN) begin
      if (sub_q != '0) begin
        sub_d = sub_q - SUB_W'(1);
      end else if (sec_q != '0) begin
        sec_d = sec_q - SEC_W'(1);
        sub_d = SUB_RELOAD;
      end else begin
        timeout_d = 1'b1;
        state_d   = TMR_IDLE;
      end
    end

    // Registered so sec_left tracks the count that will be in effect next cycle.
    if (state_d == TMR_RUN) begin
      sec_left_d = sec_d + SEC_W'(1);
    end
  end

  assign timeout  = timeout_q;
  assign busy     = (state_q == TMR_RUN);
  assign sec_left = sec_left_q;

endmodule

// File: rtl/traffic_timer.sv
// rtl/traffic_timer.sv - independent short and long seconds timers for one traffic controller
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int T_SHORT  = T_SHORT_DEF,
  parameter int T_LONG   = T_LONG_DEF
) (
  input  logic             clk,
  input  logic             glob_rst,
  input  logic             start_t,
  input  logic             start_T,
  output logic             t_timeout,
  output logic             T_timeout,
  output logic             t_busy,
  output logic             T_busy,
  output logic [SEC_W-1:0] t_sec_left,
  output logic [SEC_W-1:0] T_sec_left
);

  sec_down_timer #(
    .CLK_FREQ (CLK_FREQ),
    .SEC      (T_SHORT)
  ) u_short (
    .clk      (clk),
    .glob_rst (glob_rst),
    .start    (start_t),
    .timeout  (t_timeout),
    .busy     (t_busy),
    .sec_left (t_sec_left)
  );

  sec_down_timer #(
    .CLK_FREQ (CLK_FREQ),
    .SEC      (T_LONG)
  ) u_long (
    .clk      (clk),
    .glob_rst (glob_rst),
    .start    (start_T),
    .timeout  (T_timeout),
    .busy     (T_busy),
    .sec_left (T_sec_left)
  );

endmodule

// File: tb/tb_traffic_timer.sv
// tb/tb_traffic_timer.sv - scoreboard bench for traffic_timer against a deadline-based model
module tb_traffic_timer;

  localparam int CF = 4;
  localparam int TS = 2;
  localparam int TL = 5;

  logic       clk = 1'b0;
  logic       glob_rst = 1'b1;
  logic       st_t_drv = 1'b0;
  logic       start_T = 1'b0;
  logic       chain = 1'b0;
  logic       start_t;
  logic       t_timeout, T_timeout, t_busy, T_busy;
  logic [5:0] t_sec_left, T_sec_left;

  always #5 clk = ~clk;

  assign start_t = chain ? T_timeout : st_t_drv;

  traffic_timer #(
    .CLK_FREQ (CF),
    .T_SHORT  (TS),
    .T_LONG   (TL)
  ) dut (
    .clk        (clk),
    .glob_rst   (glob_rst),
    .start_t    (start_t),
    .start_T    (start_T),
    .t_timeout  (t_timeout),
    .T_timeout  (T_timeout),
    .t_busy     (t_busy),
    .T_busy     (T_busy),
    .t_sec_left (t_sec_left),
    .T_sec_left (T_sec_left)
  );

  typedef struct packed {
    logic       t_to;
    logic       T_to;
    logic       t_b;
    logic       T_b;
    logic [5:0] t_sl;
    logic [5:0] T_sl;
  } exp_t;

  exp_t exp_q[$];
  int   tq_t[$];
  int   tq_T[$];
  int   cyc = 0;
  int   dl0 = -1;
  int   dl1 = -1;
  logic prev_Tto = 1'b0;
  bit   done = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t mon_e;

  // Model: each timer is just an absolute expiry edge; outputs follow arithmetically.
  task automatic step(input logic rst, input logic st, input logic sT);
    logic s0, s1, to0, to1;
    int   sl0, sl1;
    exp_t e;
    @(negedge clk);
    glob_rst = rst;
    st_t_drv = st;
    start_T  = sT;
    s0 = chain ? prev_Tto : st;
    s1 = sT;
    @(posedge clk);
    #1;
    cyc++;
    to0 = 1'b0;
    to1 = 1'b0;
    if (rst) dl0 = -1;
    else if (s0) dl0 = cyc + TS * CF;
    else if (dl0 == cyc) begin to0 = 1'b1; dl0 = -1; end
    if (rst) dl1 = -1;
    else if (s1) dl1 = cyc + TL * CF;
    else if (dl1 == cyc) begin to1 = 1'b1; dl1 = -1; end
    sl0 = (dl0 < 0) ? 0 : (dl0 - cyc + CF - 1) / CF;
    sl1 = (dl1 < 0) ? 0 : (dl1 - cyc + CF - 1) / CF;
    if (to0) tq_t.push_back(cyc);
    if (to1) tq_T.push_back(cyc);
    e.t_to = to0;
    e.T_to = to1;
    e.t_b  = (dl0 >= 0);
    e.T_b  = (dl1 >= 0);
    e.t_sl = 6'(sl0);
    e.T_sl = 6'(sl1);
    exp_q.push_back(e);
    prev_Tto = to1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("t_timeout", int'(t_timeout), int'(mon_e.t_to));
      chk("T_timeout", int'(T_timeout), int'(mon_e.T_to));
      chk("t_busy", int'(t_busy), int'(mon_e.t_b));
      chk("T_busy", int'(T_busy), int'(mon_e.T_b));
      chk("t_sec_left", int'(t_sec_left), int'(mon_e.t_sl));
      chk("T_sec_left", int'(T_sec_left), int'(mon_e.T_sl));
    end
    if (t_timeout) begin
      if (tq_t.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL t_timeout_event cycle %0d: got pulse expected none", cyc);
      end else begin
        chk("t_timeout_cycle", cyc, tq_t.pop_front());
      end
    end
    if (T_timeout) begin
      if (tq_T.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL T_timeout_event cycle %0d: got pulse expected none", cyc);
      end else begin
        chk("T_timeout_cycle", cyc, tq_T.pop_front());
      end
    end
    if (done) begin
      chk("t_pending_timeouts", tq_t.size(), 0);
      chk("T_pending_timeouts", tq_T.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    idle(2);
    // basic short and long runs
    step(1'b0, 1'b1, 1'b0); idle(12);
    step(1'b0, 1'b0, 1'b1); idle(25);
    // retrigger at +5, then start on the expiry edge
    step(1'b0, 1'b1, 1'b0); idle(4); step(1'b0, 1'b1, 1'b0); idle(12);
    step(1'b0, 1'b1, 1'b0); idle(7); step(1'b0, 1'b1, 1'b0); idle(12);
    // parallel runs
    step(1'b0, 1'b1, 1'b1); idle(25);
    // reset mid-run, and start coincident with reset
    step(1'b0, 1'b0, 1'b1); idle(6); step(1'b1, 1'b0, 1'b0); idle(25);
    step(1'b1, 1'b1, 1'b1); idle(25);
    // held start
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
    idle(12);
    // chained handshake: start_t follows T_timeout
    chain = 1'b1;
    step(1'b0, 1'b0, 1'b1); idle(40);
    chain = 1'b0;
    idle(2);
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 59) == 0));
    end
    idle(30);
    done = 1'b1;
  end

endmodule
